// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode, type-index and immediate-format definitions
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam int NUM_TYPES = 11;

    // Bit positions inside the one-hot type vector
    typedef enum logic [3:0] {
        T_R      = 4'd0,
        T_LOAD   = 4'd1,
        T_OP_IMM = 4'd2,
        T_JALR   = 4'd3,
        T_STORE  = 4'd4,
        T_BRANCH = 4'd5,
        T_AUIPC  = 4'd6,
        T_LUI    = 4'd7,
        T_JAL    = 4'd8,
        T_FENCE  = 4'd9,
        T_SYSTEM = 4'd10
    } type_idx_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational immediate extraction and sign extension to XLEN
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        case (fmt_i)
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // XLEN >= 32; upper bits replicate the immediate sign
        imm_o       = {XLEN{imm32[31]}};
        imm_o[31:0] = imm32;
    end

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - registered RV32I decode stage behind a 2-entry skid buffer
module id_decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_M_EXT  = 1'b0,
    parameter bit EN_SYSTEM = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [XLEN-1:0]      out_pc,
    output logic [NUM_TYPES-1:0] out_type,
    output logic [XLEN-1:0]      out_imm,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [2:0]           out_funct3,
    output logic                 out_illegal,
    output logic [CNT_W-1:0]     illegal_count
);

    typedef struct packed {
        logic [31:0]          instr;
        logic [XLEN-1:0]      pc;
        logic [NUM_TYPES-1:0] ty;
        logic [XLEN-1:0]      imm;
        logic                 illegal;
    } entry_t;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [NUM_TYPES-1:0] dec_type;
    imm_fmt_e             dec_fmt;
    logic                 dec_illegal;
    logic [XLEN-1:0]      dec_imm;
    entry_t               dec_entry;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec_type    = '0;
        dec_fmt     = IMM_NONE;
        dec_illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    dec_type[T_R] = 1'b1;
                    dec_illegal = !((funct7 == F7_BASE) ||
                                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                                    (EN_M_EXT && funct7 == F7_MULDIV));
                end
                OPC_LOAD: begin
                    dec_type[T_LOAD] = 1'b1;
                    dec_fmt          = IMM_I;
                    dec_illegal      = funct3 inside {3'd3, 3'd6, 3'd7};
                end
                OPC_OP_IMM: begin
                    dec_type[T_OP_IMM] = 1'b1;
                    dec_fmt            = IMM_I;
                    dec_illegal = (funct3 == 3'b001 && funct7 != F7_BASE) ||
                                  (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT);
                end
                OPC_JALR: begin
                    dec_type[T_JALR] = 1'b1;
                    dec_fmt          = IMM_I;
                    dec_illegal      = (funct3 != 3'b000);
                end
                OPC_STORE: begin
                    dec_type[T_STORE] = 1'b1;
                    dec_fmt           = IMM_S;
                    dec_illegal       = (funct3 > 3'd2);
                end
                OPC_BRANCH: begin
                    dec_type[T_BRANCH] = 1'b1;
                    dec_fmt            = IMM_B;
                    dec_illegal        = funct3 inside {3'd2, 3'd3};
                end
                OPC_AUIPC: begin dec_type[T_AUIPC] = 1'b1; dec_fmt = IMM_U; end
                OPC_LUI:   begin dec_type[T_LUI]   = 1'b1; dec_fmt = IMM_U; end
                OPC_JAL:   begin dec_type[T_JAL]   = 1'b1; dec_fmt = IMM_J; end
                OPC_FENCE: begin
                    dec_type[T_FENCE] = 1'b1;
                    dec_fmt           = IMM_I;
                    dec_illegal       = !EN_SYSTEM;
                end
                OPC_SYSTEM: begin
                    dec_type[T_SYSTEM] = 1'b1;
                    dec_fmt            = IMM_I;
                    dec_illegal        = !EN_SYSTEM;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
        // Illegal entries still flow downstream, but carry no type and no immediate
        if (dec_illegal) begin
            dec_type = '0;
            dec_fmt  = IMM_NONE;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr[31:7]),
        .fmt_i   (dec_fmt),
        .imm_o   (dec_imm)
    );

    assign dec_entry = '{instr: in_instr, pc: in_pc, ty: dec_type, imm: dec_imm, illegal: dec_illegal};

    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   load_main_in, load_main_skid, load_skid;
    logic   in_fire, out_fire;
    entry_t main_q, skid_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready;

    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                load_main_skid = 1'b1;
                main_valid_d   = 1'b1;
                skid_valid_d   = 1'b0;
            end else begin
                load_main_in = in_fire;
                main_valid_d = in_fire;
            end
        end else if (in_fire) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    // A transfer coinciding with a flush is not counted
    always_comb begin
        cnt_d = cnt_q;
        if (!flush && out_fire && main_q.illegal && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
            if (load_main_in) begin
                main_q <= dec_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_entry;
            end
        end
    end

    assign out_valid     = main_valid_q;
    assign out_instr     = main_q.instr;
    assign out_pc        = main_q.pc;
    assign out_type      = main_q.ty;
    assign out_imm       = main_q.imm;
    assign out_illegal   = main_q.illegal;
    assign out_rd        = main_q.instr[11:7];
    assign out_rs1       = main_q.instr[19:15];
    assign out_rs2       = main_q.instr[24:20];
    assign out_funct3    = main_q.instr[14:12];
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - scoreboard bench for id_decode_stage (base and M/2-bit-counter builds)
module tb_id_decode_stage;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic out_ready = 1'b0;

    logic in_ready, out_valid, out_illegal;
    logic [31:0] out_instr, out_pc, out_imm;
    logic [NUM_TYPES-1:0] out_type;
    logic [4:0] out_rd, out_rs1, out_rs2;
    logic [2:0] out_funct3;
    logic [15:0] illegal_count;

    logic in_ready_m, out_valid_m, out_illegal_m;
    logic [31:0] out_instr_m, out_pc_m, out_imm_m;
    logic [NUM_TYPES-1:0] out_type_m;
    logic [4:0] out_rd_m, out_rs1_m, out_rs2_m;
    logic [2:0] out_funct3_m;
    logic [1:0] illegal_count_m;

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_type(out_type), .out_imm(out_imm),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    id_decode_stage #(.EN_M_EXT(1'b1), .CNT_W(2)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_instr(out_instr_m), .out_pc(out_pc_m), .out_type(out_type_m), .out_imm(out_imm_m),
        .out_rd(out_rd_m), .out_rs1(out_rs1_m), .out_rs2(out_rs2_m), .out_funct3(out_funct3_m),
        .out_illegal(out_illegal_m), .illegal_count(illegal_count_m)
    );

    typedef struct {
        logic [31:0]          instr;
        logic [31:0]          pc;
        logic [NUM_TYPES-1:0] ty;
        logic [31:0]          imm;
        logic                 ill;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int n_checks = 0;
    int n_fail = 0;
    int n_out = 0;
    logic [31:0] pc_n = 32'h1000;

    logic [31:0] tbl_instr [0:7];
    int          tbl_ty    [0:7];
    logic [31:0] tbl_imm   [0:7];

    function automatic logic [NUM_TYPES-1:0] oh(input int idx);
        oh = '0;
        if (idx >= 0) oh[idx] = 1'b1;
    endfunction

    // Scoreboard: push on accepted input, pop/compare on delivered output (base build)
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got instr %h pc %h, required no output", out_instr, out_pc);
                    end else begin
                        e = sb.pop_front();
                        n_out++;
                        if ({out_instr, out_pc, out_type, out_imm, out_illegal, out_rd, out_rs1, out_rs2, out_funct3} !==
                            {e.instr, e.pc, e.ty, e.imm, e.ill, e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12]}) begin
                            n_fail++;
                            $display("FAIL sb_entry: got instr %h pc %h type %b imm %h ill %b rd %0d, required instr %h pc %h type %b imm %h ill %b rd %0d",
                                     out_instr, out_pc, out_type, out_imm, out_illegal, out_rd,
                                     e.instr, e.pc, e.ty, e.imm, e.ill, e.instr[11:7]);
                        end
                    end
                end
                if (in_valid && in_ready) sb.push_back(cur);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [31:0] instr, input int ty, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc_n;
        cur.instr = instr;
        cur.pc    = pc_n;
        cur.ty    = oh(ty);
        cur.imm   = imm;
        cur.ill   = (ty < 0);
        pc_n      = pc_n + 32'd4;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL reset_handshake: got out_valid %b in_ready %b, required 0 1", out_valid, in_ready);
        end
        n_checks++;
        if ({out_instr, out_pc, out_type, out_imm, out_illegal, illegal_count} !== '0) begin
            n_fail++; $display("FAIL reset_data: got instr %h imm %h type %b cnt %0d, required all zero", out_instr, out_imm, out_type, illegal_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        out_ready = 1'b1;
        put(32'h00500093, T_OP_IMM, 32'h5);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_latency: got out_valid %b, required 1", out_valid);
        end
        n_checks++;
        if ({out_type, out_imm, out_rd} !== {oh(T_OP_IMM), 32'h5, 5'd1}) begin
            n_fail++; $display("FAIL single_decode: got type %b imm %h rd %0d, required type %b imm 00000005 rd 1", out_type, out_imm, out_rd, oh(T_OP_IMM));
        end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_drain: got timeout, required drained"); end
    endtask

    task automatic test_m_ext();
        bit ok;
        out_ready = 1'b1;
        put(32'h023100B3, -1, 32'h0);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_illegal, out_type} !== {1'b1, {NUM_TYPES{1'b0}}}) begin
            n_fail++; $display("FAIL mext_base: got ill %b type %b, required ill 1 type 0", out_illegal, out_type);
        end
        n_checks++;
        if ({out_illegal_m, out_type_m, out_imm_m} !== {1'b0, oh(T_R), 32'h0}) begin
            n_fail++; $display("FAIL mext_enabled: got ill %b type %b imm %h, required ill 0 type %b imm 0", out_illegal_m, out_type_m, out_imm_m, oh(T_R));
        end
        drain(ok);
        n_checks++;
        if (!ok || illegal_count !== 16'd1 || illegal_count_m !== 2'd0) begin
            n_fail++; $display("FAIL mext_count: got drained %b cnt %0d cnt_m %0d, required 1 1 0", ok, illegal_count, illegal_count_m);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        tbl_instr = '{32'hFFF00093, 32'hFE000EE3, 32'h00112223, 32'h123452B7,
                      32'h008000EF, 32'h00003003, 32'h0000000F, 32'h00000073};
        tbl_ty    = '{T_OP_IMM, T_BRANCH, T_STORE, T_LUI, T_JAL, -1, T_FENCE, T_SYSTEM};
        tbl_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h4, 32'h12345000, 32'h8, 32'h0, 32'h0, 32'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(tbl_instr[i], tbl_ty[i], tbl_imm[i]);
            tick();
            n_checks++;
            if ({out_valid, in_ready, out_instr} !== {2'b11, tbl_instr[i]}) begin
                n_fail++; $display("FAIL b2b_stream[%0d]: got valid %b ready %b instr %h, required 1 1 %h", i, out_valid, in_ready, out_instr, tbl_instr[i]);
            end
        end
        in_valid = 1'b0;
        drain(ok);
        n_checks++;
        if (!ok || illegal_count !== 16'd2) begin
            n_fail++; $display("FAIL b2b_end: got drained %b cnt %0d, required 1 2", ok, illegal_count);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] pc_a;
        int out0;
        out0 = n_out;
        out_ready = 1'b0;
        pc_a = pc_n;
        put(32'h00500093, T_OP_IMM, 32'h5);
        tick();
        put(32'h0000A103, T_LOAD, 32'h0);
        tick();
        put(32'h00000013, T_OP_IMM, 32'h0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({in_ready, out_valid, out_instr, out_pc} !== {2'b01, 32'h00500093, pc_a}) begin
                n_fail++; $display("FAIL bp_stall[%0d]: got ready %b valid %b instr %h pc %h, required 0 1 00500093 %h", k, in_ready, out_valid, out_instr, out_pc, pc_a);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        drain(ok);
        n_checks++;
        if (!ok || n_out - out0 != 3) begin
            n_fail++; $display("FAIL bp_delivered: got drained %b count %0d, required 1 3", ok, n_out - out0);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        put(32'h00500093, T_OP_IMM, 32'h5);
        tick();
        put(32'h0000A103, T_LOAD, 32'h0);
        tick();
        put(32'h00000013, T_OP_IMM, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_full: got valid %b ready %b, required 0 1", out_valid, in_ready);
        end
        put(32'h00112223, T_STORE, 32'h4);
        tick();
        put(32'h123452B7, T_LUI, 32'h12345000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_accept_discard: got valid %b ready %b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        put(32'h00500093, T_OP_IMM, 32'h5);
        tick();
        put(32'h00000000, -1, 32'h0);
        tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_valid_m, in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL rstmid_valid: got valid %b valid_m %b ready %b, required 0 0 1", out_valid, out_valid_m, in_ready);
        end
        n_checks++;
        if ({illegal_count, illegal_count_m, out_instr} !== '0) begin
            n_fail++; $display("FAIL rstmid_count: got cnt %0d cnt_m %0d instr %h, required 0 0 0", illegal_count, illegal_count_m, out_instr);
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_discard: got valid %b, required 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put(32'h00000000, -1, 32'h0);
            tick();
        end
        in_valid = 1'b0;
        drain(ok);
        n_checks++;
        if (!ok || illegal_count !== 16'd5 || illegal_count_m !== 2'd3) begin
            n_fail++; $display("FAIL saturate: got drained %b cnt %0d cnt_m %0d, required 1 5 3", ok, illegal_count, illegal_count_m);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_m_ext();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end

endmodule
